// File: rtl/bsg_cgol_pkg.sv
// rtl/bsg_cgol_pkg.sv - shared types and constants for the cgol controller
package bsg_cgol_pkg;

  localparam int board_width_gp = 8;

  typedef enum logic [2:0] {
    eIdle,
    eLoad,
    eRun,
    eCapture,
    eDone
  } cgol_ctrl_state_e;

endpackage

// File: rtl/bsg_cgol_frame_counter.sv
// rtl/bsg_cgol_frame_counter.sv - loadable, clamping down-counter of remaining frames
module bsg_cgol_frame_counter
  import bsg_cgol_pkg::*;
#(
  parameter int width_p   = 11,
  parameter int max_val_p = 1024
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic [width_p-1:0] val_i,
  input  logic               dec_i,
  output logic               is_one_o,
  output logic               is_zero_o
);

  localparam logic [width_p-1:0] max_lp = width_p'(max_val_p);

  logic [width_p-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = (val_i > max_lp) ? max_lp : val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - width_p'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign is_one_o  = (count_q == width_p'(1));
  assign is_zero_o = (count_q == '0);

endmodule

// File: rtl/bsg_cgol_ctrl.sv
// rtl/bsg_cgol_ctrl.sv - loads a board into the cell array, runs N generations, returns the result
module bsg_cgol_ctrl
  import bsg_cgol_pkg::*;
#(
  parameter int board_width_p     = board_width_gp,
  parameter int max_game_length_p = 1024,
  localparam int cells_lp         = board_width_p * board_width_p,
  localparam int cnt_width_lp     = $clog2(max_game_length_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    v_i,
  output logic                    ready_o,
  input  logic [cells_lp-1:0]     data_i,
  input  logic [cnt_width_lp-1:0] frames_i,
  output logic                    update_o,
  output logic [cells_lp-1:0]     update_val_o,
  output logic                    en_o,
  input  logic [cells_lp-1:0]     board_i,
  output logic                    v_o,
  output logic [cells_lp-1:0]     data_o,
  input  logic                    yumi_i
);

  cgol_ctrl_state_e state_q, state_d;
  logic [cells_lp-1:0] board_q, board_d;
  logic [cells_lp-1:0] result_q, result_d;
  logic cnt_load, cnt_dec, cnt_one, cnt_zero;

  bsg_cgol_frame_counter #(
    .width_p   (cnt_width_lp),
    .max_val_p (max_game_length_p)
  ) frame_counter (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .load_i    (cnt_load),
    .val_i     (frames_i),
    .dec_i     (cnt_dec),
    .is_one_o  (cnt_one),
    .is_zero_o (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    result_d = result_q;
    ready_o  = 1'b0;
    update_o = 1'b0;
    en_o     = 1'b0;
    v_o      = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      eIdle: begin
        ready_o = 1'b1;
        if (v_i) begin
          board_d  = data_i;
          cnt_load = 1'b1;
          state_d  = eLoad;
        end
      end
      eLoad: begin
        update_o = 1'b1;
        state_d  = cnt_zero ? eCapture : eRun;
      end
      eRun: begin
        // the cycle that sees count==1 is the last generation
        en_o    = 1'b1;
        cnt_dec = 1'b1;
        if (cnt_one) state_d = eCapture;
      end
      eCapture: begin
        result_d = board_i;
        state_d  = eDone;
      end
      eDone: begin
        v_o = 1'b1;
        if (yumi_i) state_d = eIdle;
      end
      default: state_d = eIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= eIdle;
      board_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      result_q <= result_d;
    end
  end

  assign update_val_o = board_q;
  assign data_o       = result_q;

endmodule

// File: tb/tb_bsg_cgol_ctrl.sv
// tb/tb_bsg_cgol_ctrl.sv - directed scoreboard bench for bsg_cgol_ctrl driving an 8x8 cell array model
module tb_bsg_cgol_ctrl;

  localparam int cw = 11;
  localparam logic [63:0] blink_h = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] blink_v = 64'h0000_0008_0808_0000;
  localparam logic [63:0] block_b = 64'h0000_0000_0006_0600;
  localparam logic [63:0] rand_b  = 64'hA5A5_0F0F_3C3C_FFFF;

  logic clk = 1'b0;
  logic reset_i, v_i, ready_o, update_o, en_o, v_o, yumi_i;
  logic [63:0] data_i, update_val_o, board_i, data_o;
  logic [cw-1:0] frames_i;
  logic [63:0] cells_q;

  int en_cnt = 0;
  bit overlap = 1'b0;
  int total = 0, passed = 0, failed = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  bsg_cgol_ctrl #(.board_width_p(8), .max_game_length_p(1024)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
    .data_i(data_i), .frames_i(frames_i), .update_o(update_o),
    .update_val_o(update_val_o), .en_o(en_o), .board_i(board_i),
    .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i)
  );

  // 8x8 cell array with dead cells beyond the edge
  function automatic logic [63:0] life_next(input logic [63:0] b);
    logic [63:0] nb;
    nb = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && (r + dr) >= 0 && (r + dr) < 8 && (c + dc) >= 0 && (c + dc) < 8)
              n += int'(b[(r + dr) * 8 + (c + dc)]);
          end
        end
        nb[r * 8 + c] = (n == 3) || (b[r * 8 + c] && n == 2);
      end
    end
    return nb;
  endfunction

  always @(posedge clk) begin
    if (update_o) cells_q <= update_val_o;
    else if (en_o) cells_q <= life_next(cells_q);
  end
  assign board_i = cells_q;

  always @(negedge clk) begin
    if (en_o) en_cnt <= en_cnt + 1;
    if (en_o && update_o) overlap <= 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input string tag, input logic [63:0] d, input int f, input logic [63:0] exp);
    chk({tag, " ready"}, 64'(ready_o), 64'd1);
    v_i = 1'b1;
    data_i = d;
    frames_i = cw'(f);
    exp_q.push_back(exp);
    step();
    v_i = 1'b0;
    data_i = {$urandom, $urandom};
    frames_i = cw'($urandom);
    chk({tag, " load update_o"}, 64'(update_o), 64'd1);
    chk({tag, " load update_val"}, update_val_o, d);
    chk({tag, " load en_o"}, 64'(en_o), 64'd0);
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input int en_start, input int exp_en, input bit take);
    int lat;
    logic [63:0] e;
    lat = 1;
    while (!v_o && lat < 3000) begin
      step();
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    chk({tag, " data"}, data_o, e);
    chk({tag, " en cycles"}, 64'(en_cnt - en_start), 64'(exp_en));
    if (take) begin
      yumi_i = 1'b1;
      chk({tag, " ready during yumi"}, 64'(ready_o), 64'd0);
      step();
      yumi_i = 1'b0;
      chk({tag, " v_o after yumi"}, 64'(v_o), 64'd0);
      chk({tag, " ready after yumi"}, 64'(ready_o), 64'd1);
    end
  endtask

  initial begin
    int e0;
    logic [63:0] d0;
    reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0; data_i = '0; frames_i = '0;
    repeat (3) step();
    reset_i = 1'b0;
    step();
    chk("reset ready_o", 64'(ready_o), 64'd1);
    chk("reset v_o", 64'(v_o), 64'd0);
    chk("reset en_o", 64'(en_o), 64'd0);
    chk("reset update_o", 64'(update_o), 64'd0);
    chk("reset data_o", data_o, 64'd0);

    e0 = en_cnt; start_job("blink1", blink_h, 1, blink_v);
    wait_done("blink1", 4, e0, 1, 1'b1);
    e0 = en_cnt; start_job("blink2", blink_h, 2, blink_h);
    wait_done("blink2", 5, e0, 2, 1'b1);
    e0 = en_cnt; start_job("block", block_b, 1000, block_b);
    wait_done("block", 1003, e0, 1000, 1'b1);
    e0 = en_cnt; start_job("zero", rand_b, 0, rand_b);
    wait_done("zero", 3, e0, 0, 1'b1);

    e0 = en_cnt; start_job("bp", blink_h, 3, blink_v);
    wait_done("bp", 6, e0, 3, 1'b0);
    d0 = data_o;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin v_i = 1'b1; data_i = rand_b; frames_i = cw'(1); end
      step();
      v_i = 1'b0;
      chk("bp v_o held", 64'(v_o), 64'd1);
      chk("bp data held", data_o, d0);
      chk("bp ready low", 64'(ready_o), 64'd0);
    end
    yumi_i = 1'b1;
    chk("bp ready same cycle as yumi", 64'(ready_o), 64'd0);
    step();
    yumi_i = 1'b0;
    chk("bp ready after yumi", 64'(ready_o), 64'd1);
    e0 = en_cnt;
    repeat (5) step();
    chk("bp ignored v_i no job", 64'({v_o, update_o}), 64'd0);
    chk("bp ignored v_i no en", 64'(en_cnt - e0), 64'd0);

    start_job("rst", block_b, 100, block_b);
    repeat (5) step();
    chk("rst mid-run en_o", 64'(en_o), 64'd1);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    void'(exp_q.pop_back());
    chk("rst en_o", 64'(en_o), 64'd0);
    chk("rst v_o", 64'(v_o), 64'd0);
    chk("rst ready_o", 64'(ready_o), 64'd1);
    chk("rst update_o", 64'(update_o), 64'd0);
    chk("rst data_o", data_o, 64'd0);
    repeat (3) step();
    chk("rst job dropped", 64'({v_o, en_o}), 64'd0);
    e0 = en_cnt; start_job("post-rst", blink_h, 1, blink_v);
    wait_done("post-rst", 4, e0, 1, 1'b1);

    e0 = en_cnt; start_job("clamp", blink_h, 2000, blink_h);
    wait_done("clamp", 1027, e0, 1024, 1'b1);

    chk("update_o/en_o overlap", 64'(overlap), 64'd0);
    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
